// File: rtl/button_edge_catcher.sv
// Multi-channel button conditioner: two-flop synchronizer, per-channel debounce
// counter, mode-selected one-clock edge pulse and sticky event flag.
module button_edge_catcher #(
    parameter int N         = 4,
    parameter int DB_CYCLES = 8,
    parameter int CW        = $clog2(DB_CYCLES + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] myin,
    input  logic [1:0]   mode,
    input  logic [N-1:0] clr,
    output logic [N-1:0] myout,
    output logic [N-1:0] flag,
    output logic [N-1:0] level
);

    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic [N-1:0]  s1;
    logic [N-1:0]  s2;
    logic [CW-1:0] cnt [N];
    logic [N-1:0]  qual;

    // s2 is the level about to be accepted: mode[0] admits rises, mode[1] falls.
    always_comb begin
        qual = (s2 & {N{mode[0]}}) | (~s2 & {N{mode[1]}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            level <= '0;
            myout <= '0;
            flag  <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= myin;
            s2 <= s1;
            for (int unsigned i = 0; i < N; i++) begin
                myout[i] <= 1'b0;
                // A pulse registered last edge sets the flag even if clr is high now.
                flag[i]  <= myout[i] | (flag[i] & ~clr[i]);
                if (s2[i] != level[i]) begin
                    if (cnt[i] == LAST) begin
                        level[i] <= s2[i];
                        cnt[i]   <= '0;
                        myout[i] <= qual[i];
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_edge_catcher.sv
// Directed bench for button_edge_catcher (N=4, DB_CYCLES=8, 2 ns clock).
`timescale 1ns/100ps
module tb_button_edge_catcher;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] myin;
    logic [1:0]   mode;
    logic [N-1:0] clr;
    logic [N-1:0] myout;
    logic [N-1:0] flag;
    logic [N-1:0] level;

    int tests;
    int failed;

    button_edge_catcher #(
        .N         (N),
        .DB_CYCLES (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .myin  (myin),
        .mode  (mode),
        .clr   (clr),
        .myout (myout),
        .flag  (flag),
        .level (level)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int   pulses;
    int   wide;
    int   lvl_changes;
    logic prev;
    logic prev_lvl;
    logic seen_out;
    logic seen_lvl;

    initial begin
        tests  = 0;
        failed = 0;
        rst    = 1'b1;
        myin   = '0;
        mode   = 2'b01;
        clr    = '0;

        #3;
        check("reset_level", 32'(level), 32'h0);
        check("reset_myout", 32'(myout), 32'h0);
        check("reset_flag",  32'(flag),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(2);

        // Rising edge on channel 0, mode 01
        myin[0] = 1'b1;
        step(9);
        check("rise_pre_level", 32'(level), 32'h0);
        check("rise_pre_myout", 32'(myout), 32'h0);
        step(1);
        check("rise_level", 32'(level), 32'h1);
        check("rise_myout", 32'(myout), 32'h1);
        check("rise_flag_not_yet", 32'(flag), 32'h0);
        step(1);
        check("rise_myout_end", 32'(myout), 32'h0);
        check("rise_flag", 32'(flag), 32'h1);
        step(5);

        // 5-clock glitch on channel 1 must be rejected
        seen_out = 1'b0;
        seen_lvl = 1'b0;
        myin[1]  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(1);
            seen_out |= myout[1];
            seen_lvl |= level[1];
        end
        myin[1] = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step(1);
            seen_out |= myout[1];
            seen_lvl |= level[1];
        end
        check("bounce_myout", 32'(seen_out), 32'h0);
        check("bounce_level", 32'(seen_lvl), 32'h0);
        check("bounce_flag",  32'(flag), 32'h1);

        // Falling-only mode on channel 2
        mode    = 2'b10;
        pulses  = 0;
        myin[2] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (myout[2]) pulses++;
        end
        check("fall_rise_pulses", 32'(pulses), 32'h0);
        check("fall_rise_level", 32'(level), 32'h5);
        myin[2] = 1'b0;
        step(9);
        check("fall_pre_level", 32'(level), 32'h5);
        check("fall_pre_myout", 32'(myout), 32'h0);
        step(1);
        check("fall_level", 32'(level), 32'h1);
        check("fall_myout", 32'(myout), 32'h4);
        step(1);
        check("fall_myout_end", 32'(myout), 32'h0);
        check("fall_flag", 32'(flag), 32'h5);
        step(8);

        // Both-edge mode on channel 3, four toggles
        mode   = 2'b11;
        pulses = 0;
        wide   = 0;
        prev   = 1'b0;
        for (int t = 0; t < 4; t++) begin
            myin[3] = ~myin[3];
            for (int c = 0; c < 20; c++) begin
                step(1);
                if (myout[3]) pulses++;
                if (myout[3] && prev) wide++;
                prev = myout[3];
            end
        end
        check("both_pulses", 32'(pulses), 32'h4);
        check("both_wide",   32'(wide),   32'h0);
        check("both_level",  32'(level),  32'h1);
        check("both_flag",   32'(flag),   32'hD);
        clr = 4'b1000;
        step(1);
        clr = '0;
        check("clr3_flag", 32'(flag), 32'h5);

        // Mode 00: level still tracks, no pulses, flags untouched
        mode        = 2'b00;
        pulses      = 0;
        lvl_changes = 0;
        prev_lvl    = level[3];
        for (int t = 0; t < 4; t++) begin
            myin[3] = ~myin[3];
            for (int c = 0; c < 20; c++) begin
                step(1);
                if (myout[3]) pulses++;
                if (level[3] != prev_lvl) lvl_changes++;
                prev_lvl = level[3];
            end
        end
        check("off_pulses", 32'(pulses), 32'h0);
        check("off_level_changes", 32'(lvl_changes), 32'h4);
        check("off_flag", 32'(flag), 32'h5);

        // clr coincident with flag-setting edge: set wins; then clr alone clears
        mode    = 2'b11;
        myin[0] = 1'b0;
        step(9);
        check("setwin_pre_myout", 32'(myout), 32'h0);
        step(1);
        check("setwin_myout", 32'(myout), 32'h1);
        check("setwin_level", 32'(level), 32'h0);
        clr = 4'b0001;
        step(1);
        check("setwin_flag", 32'(flag), 32'h5);
        step(1);
        check("clr0_flag", 32'(flag), 32'h4);
        clr = '0;
        step(4);

        // Reset mid-debounce
        myin[0] = 1'b1;
        step(3);
        rst = 1'b1;
        #0.5;
        check("midrst_level", 32'(level), 32'h0);
        check("midrst_myout", 32'(myout), 32'h0);
        check("midrst_flag",  32'(flag),  32'h0);
        step(3);
        check("hold_rst_level", 32'(level), 32'h0);
        check("hold_rst_flag",  32'(flag),  32'h0);
        rst = 1'b0;
        step(9);
        check("postrst_pre_level", 32'(level), 32'h0);
        step(1);
        check("postrst_level", 32'(level), 32'h1);
        check("postrst_myout", 32'(myout), 32'h1);
        step(1);
        check("postrst_flag", 32'(flag), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/button_edge_catcher.md
BUTTON_EDGE_CATCHER -- requirements
Module: button_edge_catcher

Interface
REQ-001 Parameter N, default 4, number of independent input channels (N >= 1).
REQ-002 Parameter DB_CYCLES, default 8, consecutive stable clocks required to accept a level change (DB_CYCLES >= 1).
REQ-003 Parameter CW, default $clog2(DB_CYCLES+1), debounce counter width.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 myin  input  N  raw, asynchronous, possibly bouncing channel inputs.
REQ-007 mode  input  2  edge select, shared by all channels: 00 off, 01 rising, 10 falling, 11 both.
REQ-008 clr  input  N  per-channel synchronous clear of the sticky flag.
REQ-009 myout  output  N  per-channel registered one-clock pulse on a qualifying debounced edge.
REQ-010 flag  output  N  per-channel sticky event flag.
REQ-011 level  output  N  per-channel debounced level.

Function
REQ-012 Each myin bit SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-013 Per channel, while s2 != level, the counter SHALL increment each clock.
REQ-014 When s2 != level and counter == DB_CYCLES-1, level SHALL take s2 and the counter SHALL return to 0 on that edge.
REQ-015 Whenever s2 == level, the counter SHALL be 0 on the next edge (a glitch shorter than DB_CYCLES clocks leaves level unchanged).
REQ-016 Latency: a myin change stable before edge k SHALL appear on level at edge k+1+DB_CYCLES (k+9 for the default).
REQ-017 myout[i] SHALL be 1 for exactly one clock, registered on the same edge level[i] changes, when the change qualifies under mode.
REQ-018 Qualifying changes: 0->1 for mode 01; 1->0 for mode 10; either for 11; none for 00.
REQ-019 Mode 00 SHALL still update level; only myout and flag setting are suppressed.
REQ-020 mode SHALL be sampled on the edge where level changes; a mode change takes effect for the next level change, with no pulse generated retroactively.
REQ-021 flag[i] SHALL set on the edge after myout[i]=1 and hold until clr[i] is sampled high.
REQ-022 If clr[i] and a new pulse occur on the same edge, flag[i] SHALL be 1 (set wins).
REQ-023 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each produce their own pulse.
REQ-024 Minimum event spacing: two accepted edges on one channel are at least DB_CYCLES clocks apart; no pulse is ever longer than one clock.
REQ-025 Counter SHALL never exceed DB_CYCLES-1; no wrap-around is possible.

Reset
REQ-026 While rst=1: s1, s2, level, counters, myout and flag SHALL all be 0, independent of clk.
REQ-027 After rst falls with myin held 1, the channel SHALL see a 0->1 debounced edge after the REQ-016 latency (rising pulse if mode is 01/11).
REQ-028 A reset asserted mid-debounce SHALL discard the partial count; counting restarts after release.

Verification (N=4, DB_CYCLES=8, 2 ns clock)
REQ-029 mode=01, myin[0] 0->1 held 100 ns -> level[0]=1 and myout[0] one-clock pulse 9 clocks after the first sampling edge; flag[0]=1 the next clock.
REQ-030 mode=01, myin[1] pulses high for 5 clocks (bounce) -> level[1], myout[1], flag[1] stay 0.
REQ-031 mode=10, myin[2] 1 then 0, each held 20 clocks -> exactly one myout[2] pulse, at the 1->0 level change.
REQ-032 mode=11, myin[3] toggled every 20 clocks four times -> four single-clock pulses; mode=00 repeat -> level toggles, no pulses, flag unchanged.
REQ-033 flag[0]=1, clr[0]=1 coincident with a new myout[0] pulse -> flag[0] stays 1; clr[0]=1 alone -> flag[0]=0 the next clock.
REQ-034 rst pulsed 3 clocks after a myin[0] change -> all outputs 0 during reset; level[0] follows the REQ-016 latency counted from reset release.
